// File: rtl/datapath_pkg.sv
// Shared widths and A-source select encodings for the accumulator datapath.
package datapath_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned MEM_DEPTH = 32;
  localparam int unsigned OPCODE_W  = 3;

  typedef enum logic [1:0] {
    ASEL_ALU  = 2'd0,
    ASEL_IN   = 2'd1,
    ASEL_MEM  = 2'd2,
    ASEL_ZERO = 2'd3
  } asel_e;

endpackage

// File: rtl/ram32x8.sv
// 32x8 program/data RAM: synchronous write, asynchronous read, no reset.
module ram32x8
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/datapath.sv
// 8-bit accumulator datapath: RAM, IR, PC and A, sequenced by an external controller.
module datapath
  import datapath_pkg::*;
(
  input  logic                Clock,
  input  logic                Reset,
  input  logic                PCload,
  input  logic                JMPmux,
  input  logic                IRload,
  input  logic                Meminst,
  input  logic                MemWr,
  input  logic                Aload,
  input  logic                Sub,
  input  logic [1:0]          Asel,
  output logic                Aeq0,
  output logic                Apos,
  output logic [OPCODE_W-1:0] IR,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   dataOut
);

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] ir_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] m;
  logic [DATA_W-1:0] alu;
  logic [DATA_W-1:0] a_next;

  assign addr = Meminst ? ir_q[ADDR_W-1:0] : pc_q;

  ram32x8 u_ram (
    .clk   (Clock),
    .we    (MemWr),
    .addr  (addr),
    .wdata (a_q),
    .rdata (m)
  );

  always_comb begin
    alu = Sub ? (a_q - m) : (a_q + m);
  end

  always_comb begin
    a_next = alu;
    unique case (asel_e'(Asel))
      ASEL_ALU:  a_next = alu;
      ASEL_IN:   a_next = data_in;
      ASEL_MEM:  a_next = m;
      ASEL_ZERO: a_next = '0;
      default:   a_next = alu;
    endcase
  end

  // RAM write, A, IR and PC all sample pre-edge values, so overlapping loads need no ordering.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_q  <= '0;
      ir_q <= '0;
      pc_q <= '0;
    end else begin
      if (Aload)  a_q  <= a_next;
      if (IRload) ir_q <= m;
      if (PCload) pc_q <= JMPmux ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
    end
  end

  assign dataOut = a_q;
  assign Aeq0    = (a_q == '0);
  assign Apos    = ~a_q[DATA_W-1];
  assign IR      = ir_q[DATA_W-1 -: OPCODE_W];

endmodule

// File: tb/tb_datapath.sv
// Directed test-plan sequence followed by randomized control traffic, checked against an ISA-level model.
module tb_datapath;

  logic       Clock = 1'b0;
  logic       Reset, PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub;
  logic [1:0] Asel;
  logic [7:0] data_in;
  logic       Aeq0, Apos;
  logic [2:0] IR;
  logic [7:0] dataOut;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] m_a, m_ir;
  int         m_pc;
  logic [7:0] m_ram [32];

  datapath dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .PCload  (PCload),
    .JMPmux  (JMPmux),
    .IRload  (IRload),
    .Meminst (Meminst),
    .MemWr   (MemWr),
    .Aload   (Aload),
    .Sub     (Sub),
    .Asel    (Asel),
    .Aeq0    (Aeq0),
    .Apos    (Apos),
    .IR      (IR),
    .data_in (data_in),
    .dataOut (dataOut)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one clock: every update reads the state as it was before the edge.
  task automatic step(input logic rst, pcl, jmp, irl, mi, mw, al, sb,
                      input logic [1:0] as, input logic [7:0] din);
    int         addr;
    logic [7:0] mval, na, nir;
    int         npc;
    Reset = rst; PCload = pcl; JMPmux = jmp; IRload = irl; Meminst = mi;
    MemWr = mw; Aload = al; Sub = sb; Asel = as; data_in = din;
    addr = mi ? int'(m_ir % 32) : m_pc;
    mval = m_ram[addr];
    na = m_a; nir = m_ir; npc = m_pc;
    if (rst) begin
      na = 0; nir = 0; npc = 0;
    end else begin
      if (al) begin
        if (as == 0)      na = sb ? 8'((int'(m_a) - int'(mval) + 256) % 256)
                                  : 8'((int'(m_a) + int'(mval)) % 256);
        else if (as == 1) na = din;
        else if (as == 2) na = mval;
        else              na = 0;
      end
      if (irl) nir = mval;
      if (pcl) npc = jmp ? int'(m_ir % 32) : (m_pc + 1) % 32;
    end
    if (mw) m_ram[addr] = m_a;
    @(posedge Clock);
    m_a = na; m_ir = nir; m_pc = npc;
    #1;
    chk("dataOut", dataOut, m_a);
    chk("Aeq0", 8'(Aeq0), 8'(m_a == 0));
    chk("Apos", 8'(Apos), 8'(m_a < 128));
    chk("IR", 8'(IR), 8'(m_ir / 32));
  endtask

  //                  rst pcl jmp irl mi mw al sb as din
  task automatic load_a(input logic [7:0] v);
    step(0, 0, 0, 0, 0, 0, 1, 0, 2'd1, v);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_ram[i] = 'x;
    m_a = 0; m_ir = 0; m_pc = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0);
    chk("rst_dataOut", dataOut, 8'd0);
    chk("rst_flags", {6'd0, Aeq0, Apos}, 8'b11);
    load_a(8'd5);
    chk("plan_a5", {dataOut[6:0], Aeq0}, {7'd5, 1'b0});
    step(0, 0, 0, 0, 1, 1, 0, 0, 2'd0, 8'd0);
    step(0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 8'd0);
    step(0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 8'd0);
    chk("plan_add15", dataOut, 8'd15);
    step(0, 0, 0, 0, 1, 0, 1, 1, 2'd0, 8'd0);
    step(0, 0, 0, 0, 1, 0, 1, 1, 2'd0, 8'd0);
    chk("plan_sub5", dataOut, 8'd5);
    step(0, 0, 0, 1, 1, 0, 0, 0, 2'd0, 8'd0);
    step(0, 0, 0, 0, 1, 0, 1, 0, 2'd1, 8'd3);
    step(0, 0, 0, 0, 1, 1, 0, 0, 2'd0, 8'd0);
    step(0, 0, 0, 0, 1, 0, 1, 0, 2'd3, 8'd0);
    step(0, 0, 0, 0, 1, 0, 1, 0, 2'd2, 8'd0);
    chk("plan_ram5", dataOut, 8'd3);
    step(0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 8'd0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0);
    load_a(8'd1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 8'd0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 2'd3, 8'd0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 2'd2, 8'd0);
    chk("plan_ram6", dataOut, 8'd1);
    load_a(8'd200);
    chk("plan_apos0", 8'(Apos), 8'd0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 8'd0);
    step(0, 0, 0, 0, 1, 0, 1, 0, 2'd2, 8'd0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 2'd2, 8'd0);
    chk("plan_ram6_200", dataOut, 8'd200);
    load_a(8'd10);
    step(0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 8'd0);
    load_a(8'd250);
    step(0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 8'd0);
    chk("plan_wrap4", dataOut, 8'd4);
    load_a(8'd31);
    step(0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 8'd0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 8'd0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 8'd0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 2'd2, 8'd0);
    chk("plan_pcwrap", dataOut, 8'd5);
    load_a(8'd77);
    step(1, 1, 0, 1, 0, 0, 1, 0, 2'd1, 8'd99);
    chk("plan_midrst", {dataOut[6:0], Aeq0}, 8'd1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 2'd2, 8'd0);
    chk("plan_ram_kept", dataOut, 8'd5);

    // Fill every RAM word so random traffic never reads an unwritten location.
    step(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0);
    for (int i = 0; i < 32; i++)
      step(0, 1, 0, 0, 0, 1, 1, 0, 2'd1, 8'($urandom));

    for (int i = 0; i < 600; i++) begin
      logic rst;
      rst = ($urandom_range(0, 39) == 0);
      step(rst, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           rst ? 1'b0 : 1'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
